// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: multi-cycle LDM/STM block-transfer engine.
// It walks a register list lowest-index first, issuing one register-file
// access and one data-memory access per cycle. It then spends an optional
// base-writeback cycle and pulses done. All strobes are decoded
// combinationally from the registered state, so the combinational read data
// (rf_rd, mem_rdata) is consumed in the same cycle it is addressed.
module ldm_stm_sequencer #(
    parameter int REG_N = 16,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_load,
    input  logic             p_bit,
    input  logic             u_bit,
    input  logic             w_bit,
    input  logic [3:0]       rn,
    input  logic [REG_N-1:0] reglist,
    input  logic [31:0]      base,
    output logic [3:0]       rf_ra,
    input  logic [31:0]      rf_rd,
    output logic             rf_we,
    output logic [3:0]       rf_wa,
    output logic [31:0]      rf_wd,
    output logic             pc_we,
    output logic [31:0]      pc_wd,
    output logic [31:0]      mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(REG_N + 1);
    localparam int IDX_W = $clog2(REG_N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_WB,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Transfer context captured when a request is accepted.
    logic [REG_N-1:0] list_q;     // registers still to transfer
    logic [31:0]      cur_q;      // address of the next transfer
    logic [31:0]      wb_data_q;  // final base value for writeback
    logic [3:0]       rn_q;
    logic             is_load_q;
    logic             w_q;
    logic             wb_kill_q;  // writeback suppressed (rn=PC or loaded base)

    // Start-time decode.
    logic [CNT_W-1:0] start_cnt;
    logic [31:0]      start_span;
    logic [31:0]      start_aligned;
    logic [31:0]      start_addr;
    logic [31:0]      start_wb;

    // Per-transfer decode.
    logic [IDX_W-1:0] xfer_idx;
    logic [REG_N-1:0] xfer_bit;
    logic [REG_N-1:0] list_rest;
    logic             xfer_is_pc;

    function automatic logic [CNT_W-1:0] popcount(input logic [REG_N-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < REG_N; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_set(input logic [REG_N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = REG_N - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Lowest transfer address and writeback value for an incoming request.
    always_comb begin
        start_cnt     = popcount(reglist);
        start_span    = 32'(start_cnt) * 32'(STEP);
        start_aligned = {base[31:2], 2'b00};
        // Lowest register always goes to the lowest address, so decrement
        // modes start at the bottom of the block and walk upwards.
        case ({p_bit, u_bit})
            2'b01:   start_addr = start_aligned;
            2'b11:   start_addr = start_aligned + 32'(STEP);
            2'b00:   start_addr = start_aligned - start_span + 32'(STEP);
            default: start_addr = start_aligned - start_span;
        endcase
        // Writeback uses the unmasked base.
        start_wb = u_bit ? (base + start_span) : (base - start_span);
    end

    // Pick the next register to move and what remains after it.
    always_comb begin
        xfer_idx   = lowest_set(list_q);
        xfer_bit   = REG_N'(1) << xfer_idx;
        list_rest  = list_q & ~xfer_bit;
        xfer_is_pc = (xfer_idx == IDX_W'(REG_N - 1));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every flop samples
        // the pre-edge values of the others, independent of statement order.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the request in IDLE; advance list and address per transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            list_q    <= '0;
            cur_q     <= '0;
            wb_data_q <= '0;
            rn_q      <= '0;
            is_load_q <= 1'b0;
            w_q       <= 1'b0;
            wb_kill_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            list_q    <= reglist;
            cur_q     <= start_addr;
            wb_data_q <= start_wb;
            rn_q      <= rn;
            is_load_q <= is_load;
            w_q       <= w_bit;
            wb_kill_q <= (rn == 4'd15) || (is_load && reglist[rn]);
        end else if (state == S_XFER) begin
            list_q <= list_rest;
            cur_q  <= cur_q + 32'(STEP);
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave a signal unassigned, which would otherwise infer a latch.
        state_nxt = state;
        rf_ra     = '0;
        rf_we     = 1'b0;
        rf_wa     = '0;
        rf_wd     = '0;
        pc_we     = 1'b0;
        pc_wd     = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (reglist != '0) ? S_XFER : S_DONE;
                end
            end

            S_XFER: begin
                busy     = 1'b1;
                mem_addr = cur_q;
                if (is_load_q) begin
                    if (xfer_is_pc) begin
                        pc_we = 1'b1;
                        pc_wd = mem_rdata & 32'hFFFF_FFFC;
                    end else begin
                        rf_we = 1'b1;
                        rf_wa = 4'(xfer_idx);
                        rf_wd = mem_rdata;
                    end
                end else begin
                    rf_ra     = 4'(xfer_idx);
                    mem_we    = 1'b1;
                    mem_wdata = rf_rd;
                end
                if (list_rest == '0) begin
                    state_nxt = w_q ? S_WB : S_DONE;
                end
            end

            S_WB: begin
                busy      = 1'b1;
                rf_we     = ~wb_kill_q;
                rf_wa     = rn_q;
                rf_wd     = wb_data_q;
                state_nxt = S_DONE;
            end

            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer. The driver issues transfers and
// pushes the expected per-cycle bus activity computed from a list-based
// reference model. The monitor pops one entry for every busy cycle and
// checks that the buses stay quiet whenever the sequencer is idle.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_load;
    logic        p_bit;
    logic        u_bit;
    logic        w_bit;
    logic [3:0]  rn;
    logic [15:0] reglist;
    logic [31:0] base;
    logic [3:0]  rf_ra;
    logic [31:0] rf_rd;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    ldm_stm_sequencer #(.REG_N(16), .STEP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_load   (is_load),
        .p_bit     (p_bit),
        .u_bit     (u_bit),
        .w_bit     (w_bit),
        .rn        (rn),
        .reglist   (reglist),
        .base      (base),
        .rf_ra     (rf_ra),
        .rf_rd     (rf_rd),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .pc_we     (pc_we),
        .pc_wd     (pc_wd),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

    // Environment: register file contents, PC, memory pattern and overrides.
    logic [31:0] rf_arr [16];
    logic [31:0] pc_val;
    logic [31:0] mem_key;
    logic [31:0] ovr_addr [4];
    logic [31:0] ovr_data [4];
    int          ovr_n;

    // Combinational memory: address-keyed pattern with a few fixed words.
    always_comb begin
        mem_rdata = mem_addr ^ mem_key;
        for (int k = 0; k < 4; k++) begin
            if (k < ovr_n && ovr_addr[k] == mem_addr) mem_rdata = ovr_data[k];
        end
    end

    // Combinational register-file read port; R15 reads as PC+8.
    always_comb begin
        rf_rd = pc_val + 32'd8;
        if (rf_ra != 4'd15) rf_rd = rf_arr[rf_ra];
    end

    function automatic logic [31:0] ref_mem(input logic [31:0] a);
        logic [31:0] v;
        v = a ^ mem_key;
        for (int k = 0; k < 4; k++) begin
            if (k < ovr_n && ovr_addr[k] == a) v = ovr_data[k];
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_rf(input int r);
        return (r == 15) ? pc_val + 32'd8 : rf_arr[r];
    endfunction

    typedef struct {
        logic        done;
        logic        rf_we;
        logic [3:0]  rf_wa;
        logic [31:0] rf_wd;
        logic        pc_we;
        logic [31:0] pc_wd;
        logic        addr_v;
        logic [31:0] mem_addr;
        logic        mem_we;
        logic [31:0] mem_wdata;
    } exp_t;

    exp_t sb_q [$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Reference model: list the selected registers in ascending order, lay
    // them out on consecutive words starting at the lowest block address,
    // then append writeback (if any) and the completion pulse.
    task automatic build_expect(input logic ld, input logic p, input logic u, input logic w,
                                input logic [3:0] rn_v, input logic [15:0] rl,
                                input logic [31:0] b, input int keep);
        int          regs [$];
        exp_t        recs [$];
        exp_t        e;
        logic [31:0] span;
        logic [31:0] lo;
        logic [31:0] a;
        for (int r = 0; r < 16; r++) if (rl[r]) regs.push_back(r);
        span = 32'(regs.size()) * 32'd4;
        lo   = b & 32'hFFFF_FFFC;
        if (u) lo = p ? lo + 32'd4 : lo;
        else   lo = p ? lo - span : lo - span + 32'd4;
        for (int k = 0; k < regs.size(); k++) begin
            e = '{default: '0};
            a = lo + 32'(k) * 32'd4;
            e.addr_v   = 1'b1;
            e.mem_addr = a;
            if (ld) begin
                if (regs[k] == 15) begin
                    e.pc_we = 1'b1;
                    e.pc_wd = ref_mem(a) & 32'hFFFF_FFFC;
                end else begin
                    e.rf_we = 1'b1;
                    e.rf_wa = 4'(regs[k]);
                    e.rf_wd = ref_mem(a);
                end
            end else begin
                e.mem_we    = 1'b1;
                e.mem_wdata = ref_rf(regs[k]);
            end
            recs.push_back(e);
        end
        if (w && regs.size() != 0) begin
            e = '{default: '0};
            e.rf_we = !(rn_v == 4'd15 || (ld && rl[rn_v]));
            e.rf_wa = rn_v;
            e.rf_wd = u ? b + span : b - span;
            recs.push_back(e);
        end
        e = '{default: '0};
        e.done = 1'b1;
        recs.push_back(e);
        for (int k = 0; k < recs.size(); k++) begin
            if (keep < 0 || k < keep) sb_q.push_back(recs[k]);
        end
    endtask

    // Monitor: one expected entry per busy cycle, quiet buses otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                if (sb_q.size() == 0) begin
                    check("busy_unexpected", 32'(busy), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("done",   32'(done),   32'(mon_e.done));
                    check("rf_we",  32'(rf_we),  32'(mon_e.rf_we));
                    check("pc_we",  32'(pc_we),  32'(mon_e.pc_we));
                    check("mem_we", 32'(mem_we), 32'(mon_e.mem_we));
                    if (mon_e.rf_we) begin
                        check("rf_wa", 32'(rf_wa), 32'(mon_e.rf_wa));
                        check("rf_wd", rf_wd, mon_e.rf_wd);
                    end
                    if (mon_e.pc_we)  check("pc_wd", pc_wd, mon_e.pc_wd);
                    if (mon_e.addr_v) check("mem_addr", mem_addr, mon_e.mem_addr);
                    if (mon_e.mem_we) check("mem_wdata", mem_wdata, mon_e.mem_wdata);
                end
            end else begin
                check("idle_strobes", 32'({done, rf_we, pc_we, mem_we}), 32'd0);
                check("idle_buses",
                      32'(|{rf_ra, rf_wa, rf_wd, pc_wd, mem_addr, mem_wdata}), 32'd0);
            end
        end
    end

    task automatic env_default();
        mem_key = 32'h5A5A_0000;
        pc_val  = 32'h0000_8000;
        ovr_n   = 0;
        for (int r = 0; r < 16; r++) rf_arr[r] = 32'hC000_0000 + 32'(r);
    endtask

    task automatic add_ovr(input logic [31:0] a, input logic [31:0] d);
        ovr_addr[ovr_n] = a;
        ovr_data[ovr_n] = d;
        ovr_n++;
    endtask

    // Issue one request and wait (bounded) for the sequencer to go idle.
    // poke: pulse start again while busy. abort: reset in the 2nd transfer.
    task automatic run_txn(input logic ld, input logic p, input logic u, input logic w,
                           input logic [3:0] rn_v, input logic [15:0] rl,
                           input logic [31:0] b, input bit poke, input bit abort);
        @(posedge clk);
        #1;
        is_load = ld;
        p_bit   = p;
        u_bit   = u;
        w_bit   = w;
        rn      = rn_v;
        reglist = rl;
        base    = b;
        start   = 1'b1;
        build_expect(ld, p, u, w, rn_v, rl, b, abort ? 2 : -1);
        @(posedge clk);
        #1;
        start   = 1'b0;
        is_load = 1'($urandom_range(0, 1));
        u_bit   = 1'($urandom_range(0, 1));
        w_bit   = 1'($urandom_range(0, 1));
        rn      = 4'($urandom_range(0, 15));
        reglist = 16'($urandom);
        base    = $urandom;
        if (poke) begin
            start   = 1'b1;
            reglist = 16'hFFFF;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (abort) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_mem_we", 32'(mem_we), 32'd0);
        end
        for (int i = 0; i < 40 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("txn_end_busy", 32'(busy), 32'd0);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        logic [15:0] rl;
        logic [31:0] b;

        reset   = 1'b1;
        start   = 1'b0;
        is_load = 1'b0;
        p_bit   = 1'b0;
        u_bit   = 1'b0;
        w_bit   = 1'b0;
        rn      = '0;
        reglist = '0;
        base    = '0;
        env_default();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_strobes", 32'({done, rf_we, pc_we, mem_we}), 32'd0);
        check("reset_buses", 32'(|{rf_ra, rf_wa, rf_wd, pc_wd, mem_addr, mem_wdata}), 32'd0);
        mon_en = 1'b1;

        // STM IA, R1..R3, no writeback.
        env_default();
        rf_arr[1] = 32'h11;
        rf_arr[2] = 32'h22;
        rf_arr[3] = 32'h33;
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h000E, 32'h100, 1'b0, 1'b0);

        // LDM IB with writeback of R4.
        env_default();
        add_ovr(32'h204, 32'hA);
        add_ovr(32'h208, 32'hB);
        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 16'h0003, 32'h200, 1'b0, 1'b0);

        // LDM DB including PC, writeback of R13.
        env_default();
        add_ovr(32'hFF8, 32'h5);
        add_ovr(32'hFFC, 32'h2002);
        run_txn(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 16'h8010, 32'h1000, 1'b0, 1'b0);

        // LDM whose list contains the base: writeback suppressed.
        env_default();
        add_ovr(32'h300, 32'h77);
        run_txn(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 16'h0004, 32'h300, 1'b0, 1'b0);

        // Empty list, with and without writeback requested.
        env_default();
        run_txn(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 16'h0000, 32'h400, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 16'h0000, 32'h400, 1'b0, 1'b0);

        // start while busy is ignored.
        run_txn(1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 16'h0A01, 32'h500, 1'b1, 1'b0);

        // Reset mid-transfer, then a clean transfer from a new base.
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h00F0, 32'h600, 1'b0, 1'b1);
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h00F0, 32'h800, 1'b0, 1'b0);

        // Address wrap around zero, rn=PC writeback suppression, unaligned base.
        run_txn(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 16'h0007, 32'h0000_0004, 1'b0, 1'b0);
        run_txn(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 16'h800F, 32'hFFFF_FFF8, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 16'h0003, 32'h0000_0103, 1'b0, 1'b0);

        // Randomized transfers.
        for (int t = 0; t < 60; t++) begin
            mem_key = $urandom;
            pc_val  = $urandom;
            ovr_n   = 0;
            for (int r = 0; r < 16; r++) rf_arr[r] = $urandom;
            case ($urandom_range(0, 5))
                0:       rl = 16'h0000;
                1:       rl = 16'hFFFF;
                2:       rl = 16'h0001 << $urandom_range(0, 15);
                default: rl = 16'($urandom);
            endcase
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 16));
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), rl, b,
                    ($urandom_range(0, 7) == 0), 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Multi-cycle initiator for the 15-entry register file (one write port, one read port, R15 supplied externally). Executes ARM LDM/STM block transfers by walking a 16-bit register list. Each cycle it issues one register-file access plus one data-memory access, then performs optional base writeback. Sits in the datapath beside the register file and data memory. Muxed onto the RF and memory ports while busy=1.

Parameters:
REG_N, 16, architectural register count / reglist width
STEP, 4, byte stride per transferred word

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
is_load  in  1  1=LDM, 0=STM
p_bit  in  1  pre-index (before)
u_bit  in  1  1=increment, 0=decrement
w_bit  in  1  base writeback enable
rn  in  4  base register index
reglist  in  16  register list, bit i = Ri
base  in  32  current value of Rn
rf_ra  out  4  RF read address (STM data)
rf_rd  in  32  RF read data (combinational; returns PC+8 for index 15)
rf_we  out  1  RF write enable
rf_wa  out  4  RF write address
rf_wd  out  32  RF write data
pc_we  out  1  PC load strobe (LDM with R15)
pc_wd  out  32  PC load value
mem_addr  out  32  word-aligned memory address
mem_we  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data (combinational)
busy  out  1  high from first cycle after accepted start through DONE
done  out  1  one-cycle completion pulse

Behaviour:
- Clock clk; reset is synchronous and active-high (port reset). On reset: state=IDLE, rf_ra/rf_wa=0, rf_we/pc_we/mem_we=0, rf_wd/pc_wd/mem_addr/mem_wdata=0, busy=0, done=0. Reset mid-transfer aborts immediately; no further strobes.
- States: IDLE, XFER, WB, DONE.
- IDLE: on start=1, latch reglist, base, rn, is_load, p, u, w. Compute cnt=popcount(reglist) and b=base with [1:0] forced to 0. Set start address a0 as follows:
  - IA (p=0,u=1): b
  - IB (p=1,u=1): b+4
  - DA (p=0,u=0): b-4*cnt+4
  - DB (p=1,u=0): b-4*cnt
  Next state is XFER if cnt!=0, else DONE. start is ignored outside IDLE.
- XFER, one register per cycle: i = lowest set bit of the remaining list. Registers are always transferred lowest-index to lowest-address. mem_addr=cur.
  - Load, i<15: rf_we=1, rf_wa=i, rf_wd=mem_rdata.
  - Load, i=15: rf_we=0, pc_we=1, pc_wd=mem_rdata & 32'hFFFF_FFFC.
  - Store: rf_ra=i, mem_we=1, mem_wdata=rf_rd.
  - Then clear bit i and set cur+=4. When the remaining list reaches 0, go to WB if w=1, else DONE.
- WB, one cycle: rf_we=1, rf_wa=rn, rf_wd = base+4*cnt (u=1) or base-4*cnt (u=0), computed from the unmasked base. Writeback is suppressed (rf_we=0, cycle still spent) in either case:
  - rn=15
  - is_load=1 and reglist[rn]=1 (the loaded value wins)
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in XFER, WB and DONE.
- Strobes are asserted only in the states listed above; otherwise 0.
- Latency: start accepted at cycle 0; transfers in cycles 1..cnt; WB in cycle cnt+1 (if w=1); done pulses in the following cycle.
- Empty list: done at cycle 1, no strobes.
- All address arithmetic is 32-bit modulo 2^32 (wrap past 0xFFFF_FFFC to 0 is legal).

Test Plan:
- STM IA, base=0x100, reglist=0x000E (R1..R3 = 0x11,0x22,0x33), w=0 -> mem_we on cycles 1-3 at 0x100/0x104/0x108 with data 0x11/0x22/0x33; done on cycle 4; no rf_we.
- LDM IB w=1, rn=4, base=0x200, reglist=0x0003, mem[0x204]=0xA, mem[0x208]=0xB -> R0=0xA, R1=0xB, WB R4=0x208, done on cycle 4.
- LDM DB w=1, rn=13, base=0x1000, reglist=0x8010, mem[0xFF8]=0x5, mem[0xFFC]=0x2002 -> R4=0x5; pc_we with pc_wd=0x2000 and rf_we=0 on that cycle; R13=0xFF8.
- LDM IA w=1, rn=2, reglist=0x0004, mem[base]=0x77 -> R2=0x77; WB cycle has rf_we=0; final R2=0x77.
- reglist=0 with start -> done=1 at cycle 1, busy low afterwards, all strobes 0. Separately, start pulsed while busy is ignored.
- Reset asserted in the 2nd XFER cycle of a 4-register STM -> next cycle busy=0, mem_we=0. A fresh start afterwards runs normally from its own base.
